// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main control unit.
// Optional bne support is selected by defining MIPS_CTRL_BNE_EN.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXECUTE,
    S_ALU_WB,
    S_BRANCH,
    S_JUMP,
    S_ADDI_EXEC,
    S_ADDI_WB
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

`ifdef MIPS_CTRL_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

  // Where DECODE dispatches; unsupported opcodes return to FETCH.
  function automatic state_t decode_target(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW: return S_MEM_ADDR;
      OP_RTYPE:     return S_EXECUTE;
      OP_BEQ:       return S_BRANCH;
      OP_BNE:       return BNE_EN ? S_BRANCH : S_FETCH;
      OP_J:         return S_JUMP;
      OP_ADDI:      return S_ADDI_EXEC;
      default:      return S_FETCH;
    endcase
  endfunction

  function automatic logic op_is_legal(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: return 1'b1;
      OP_BNE:  return BNE_EN;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state -> control-vector decoder for the main control FSM.
// branch_ne is live only when MIPS_CTRL_BNE_EN is defined (via mips_ctrl_pkg).
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t      state,
  input  logic        mem_ready,
  input  logic [5:0]  op,
  output ctrl_t       ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRCB_IMM_SH2;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.instr_done = ~op_is_legal(op);
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALU_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RT;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.branch_ne     = BNE_EN && (op == OP_BNE);
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle MIPS main control FSM: state register, dispatch and sticky illegal_op.
// Define MIPS_CTRL_BNE_EN to execute bne; otherwise opcode 000101 is illegal.
//
// state       | meaning
// FETCH       | read instruction at PC, PC += 4 (waits on mem_ready)
// DECODE      | compute branch target, dispatch on opcode
// MEM_ADDR    | rs + imm for lw/sw
// MEM_READ    | load data read (waits on mem_ready)
// MEM_WB      | write MDR to rt
// MEM_WRITE   | store data write (waits on mem_ready)
// EXECUTE     | R-type ALU operation
// ALU_WB      | write ALUOut to rd
// BRANCH      | compare rs/rt, conditional PC load
// JUMP        | load jump target
// ADDI_EXEC   | rs + imm
// ADDI_WB     | write ALUOut to rt
module main_control_fsm
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op_31_26,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       branch_ne,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOpcode,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal_op
);

  state_t state_q, state_d;
  logic   illegal_q;
  ctrl_t  ctrl, ctrl_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE && !op_is_legal(op_31_26))
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE:    state_d = decode_target(op_31_26);
      S_MEM_ADDR:  state_d = (op_31_26 == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECUTE:   state_d = S_ALU_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      default:     state_d = S_FETCH;
    endcase
  end

  mips_ctrl_outdec u_outdec (
    .state     (state_q),
    .mem_ready (mem_ready),
    .op        (op_31_26),
    .ctrl      (ctrl)
  );

  // Reset blanks outputs immediately so an aborted access never completes.
  assign ctrl_o      = rst ? '0 : ctrl;
  assign illegal_op  = illegal_q & ~rst;

  assign PCWrite     = ctrl_o.pc_write;
  assign PCWriteCond = ctrl_o.pc_write_cond;
  assign branch_ne   = ctrl_o.branch_ne;
  assign IorD        = ctrl_o.i_or_d;
  assign MemRead     = ctrl_o.mem_read;
  assign MemWrite    = ctrl_o.mem_write;
  assign IRWrite     = ctrl_o.ir_write;
  assign MemtoReg    = ctrl_o.mem_to_reg;
  assign RegDst      = ctrl_o.reg_dst;
  assign RegWrite    = ctrl_o.reg_write;
  assign ALUSrcA     = ctrl_o.alu_src_a;
  assign ALUSrcB     = ctrl_o.alu_src_b;
  assign ALUOpcode   = ctrl_o.alu_op;
  assign PCSource    = ctrl_o.pc_source;
  assign instr_done  = ctrl_o.instr_done;

endmodule

// File: tb/tb_main_control_fsm.sv
// Self-checking bench for main_control_fsm: per-state vector table, hand-built
// stall/reset sequences, and randomized instructions against a phase model.
module tb_main_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op_31_26;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, branch_ne, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done, illegal_op;
  logic [1:0] ALUSrcB, ALUOpcode, PCSource;

  int checks = 0;
  int errors = 0;
  bit ill_model = 1'b0;

  main_control_fsm dut (
    .clk(clk), .rst(rst), .op_31_26(op_31_26), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .branch_ne(branch_ne),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOpcode(ALUOpcode),
    .PCSource(PCSource), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  logic [17:0] act;
  assign act = {PCWrite, PCWriteCond, branch_ne, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOpcode, PCSource,
                instr_done};

  function automatic logic [17:0] cv(
      input logic pcw, pcc, bne, iord, mr, mw, irw, m2r, rdst, rw, asa,
      input logic [1:0] asb, aop, ps, input logic done);
    return {pcw, pcc, bne, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, ps, done};
  endfunction

  task automatic chk(input string name, input logic [17:0] a, input logic [17:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, a, e, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      @(negedge clk);
      chk("reset_outputs", act, 18'h0);
      chk("reset_illegal", {17'h0, illegal_op}, 18'h0);
    end
    tick();
    rst = 1'b0;
    ill_model = 1'b0;
  endtask

  // Expected behaviour of an opcode from its architectural role alone.
  function automatic bit legal(input logic [5:0] op);
    case (op)
      6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000: return 1'b1;
`ifdef MIPS_CTRL_BNE_EN
      6'b000101: return 1'b1;
`endif
      default:   return 1'b0;
    endcase
  endfunction

  // Phase letters: F fetch, R data read, W data write, N fixed single cycle.
  function automatic string phases(input logic [5:0] op);
    if (!legal(op)) return "FN";
    case (op)
      6'b100011:           return "FNNRN";
      6'b101011:           return "FNNW";
      6'b000000, 6'b001000: return "FNNN";
      default:             return "FNN";
    endcase
  endfunction

  // mode 0: random mem_ready; mode 1: fetch ready, each data access stalls 2 cycles.
  task automatic run_instr(input logic [5:0] op, input int mode, output int cycles);
    string ph;
    bit    wr, is_br, last, adv, rdy;
    byte   p;
    int    stalls;
    ph     = phases(op);
    wr     = legal(op) && (op == 6'b000000 || op == 6'b100011 || op == 6'b001000);
    is_br  = legal(op) && (op == 6'b000100 || op == 6'b000101);
    op_31_26 = op;
    cycles = 0;
    for (int i = 0; i < ph.len(); i++) begin
      stalls = 0;
      p = ph[i];
      last = (i == ph.len() - 1);
      do begin
        if (p == 8'h4E) rdy = 1'($urandom % 2);
        else if (mode == 0) rdy = ($urandom % 3 != 0) || (stalls >= 3);
        else rdy = (p == 8'h46) || (stalls >= 2);
        mem_ready = rdy;
        adv = (p == 8'h4E) || rdy;
        @(negedge clk);
        chk("MemRead",    {17'h0, MemRead},    {17'h0, p == 8'h46 || p == 8'h52});
        chk("MemWrite",   {17'h0, MemWrite},   {17'h0, p == 8'h57});
        chk("IorD",       {17'h0, IorD},       {17'h0, p == 8'h52 || p == 8'h57});
        chk("IRWrite",    {17'h0, IRWrite},    {17'h0, p == 8'h46 && rdy});
        chk("PCWrite",    {17'h0, PCWrite},
            {17'h0, (p == 8'h46 && rdy) || (last && legal(op) && op == 6'b000010)});
        chk("PCWriteCond", {17'h0, PCWriteCond}, {17'h0, last && is_br});
        chk("branch_ne",  {17'h0, branch_ne},  {17'h0, last && is_br && op == 6'b000101});
        chk("RegWrite",   {17'h0, RegWrite},   {17'h0, last && wr});
        chk("instr_done", {17'h0, instr_done}, {17'h0, last && adv});
        chk("illegal_op", {17'h0, illegal_op}, {17'h0, ill_model});
        tick();
        cycles++;
        stalls++;
      end while (!adv);
    end
    if (!legal(op)) ill_model = 1'b1;
  endtask

  typedef struct {
    logic [5:0]       op;
    int               n;
    logic [4:0][17:0] exp;
    bit               ill;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [17:0] v_fetch, v_dec, v_dec_ill, v_maddr, v_mread, v_mwb, v_mwr;
    logic [17:0] v_exec, v_alu_wb, v_beq, v_bne, v_jump, v_aexec, v_awb;
    int cyc;

    v_fetch   = cv(1,0,0,0,1,0,1,0,0,0,0, 2'b01, 2'b00, 2'b00, 0);
    v_dec     = cv(0,0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 0);
    v_dec_ill = cv(0,0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 1);
    v_maddr   = cv(0,0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0);
    v_mread   = cv(0,0,0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0);
    v_mwb     = cv(0,0,0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00, 1);
    v_mwr     = cv(0,0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 1);
    v_exec    = cv(0,0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00, 0);
    v_alu_wb  = cv(0,0,0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 2'b00, 1);
    v_beq     = cv(0,1,0,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 1);
    v_bne     = cv(0,1,1,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 1);
    v_jump    = cv(1,0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10, 1);
    v_aexec   = cv(0,0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0);
    v_awb     = cv(0,0,0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00, 1);

    tbl[0] = '{6'b000000, 4, {18'h0, v_alu_wb, v_exec, v_dec, v_fetch}, 1'b0};
    tbl[1] = '{6'b100011, 5, {v_mwb, v_mread, v_maddr, v_dec, v_fetch}, 1'b0};
    tbl[2] = '{6'b101011, 4, {18'h0, v_mwr, v_maddr, v_dec, v_fetch}, 1'b0};
    tbl[3] = '{6'b000100, 3, {18'h0, 18'h0, v_beq, v_dec, v_fetch}, 1'b0};
    tbl[4] = '{6'b000010, 3, {18'h0, 18'h0, v_jump, v_dec, v_fetch}, 1'b0};
    tbl[5] = '{6'b001000, 4, {18'h0, v_awb, v_aexec, v_dec, v_fetch}, 1'b0};
`ifdef MIPS_CTRL_BNE_EN
    tbl[6] = '{6'b000101, 3, {18'h0, 18'h0, v_bne, v_dec, v_fetch}, 1'b0};
`else
    tbl[6] = '{6'b000101, 2, {18'h0, 18'h0, 18'h0, v_dec_ill, v_fetch}, 1'b1};
`endif
    tbl[7] = '{6'b111111, 2, {18'h0, 18'h0, 18'h0, v_dec_ill, v_fetch}, 1'b1};

    rst = 1'b1;
    mem_ready = 1'b1;
    op_31_26 = 6'b000000;
    #1;

    // Per-state control vectors with memory always ready.
    foreach (tbl[t]) begin
      apply_reset(3);
      op_31_26 = tbl[t].op;
      mem_ready = 1'b1;
      for (int c = 0; c < tbl[t].n; c++) begin
        @(negedge clk);
        chk($sformatf("vec_op%02h_c%0d", tbl[t].op, c), act, tbl[t].exp[c]);
        tick();
      end
      @(negedge clk);
      chk($sformatf("next_fetch_op%02h", tbl[t].op), act, v_fetch);
      chk($sformatf("illegal_after_op%02h", tbl[t].op), {17'h0, illegal_op},
          {17'h0, tbl[t].ill});
      tick();
    end

    // Stalled lw / sw: two wait cycles on the data access.
    apply_reset(3);
    run_instr(6'b100011, 1, cyc);
    chk("lw_stall_cycles", 18'(cyc), 18'd7);
    run_instr(6'b101011, 1, cyc);
    chk("sw_stall_cycles", 18'(cyc), 18'd6);

    // Sticky illegal flag across a following addi, cleared only by reset.
    run_instr(6'b111111, 0, cyc);
    run_instr(6'b001000, 0, cyc);
    chk("addi_after_illegal_cycles", 18'(cyc >= 4), 18'd1);
    apply_reset(2);

    // Reset during a stalled store aborts it.
    op_31_26 = 6'b101011;
    mem_ready = 1'b1;
    repeat (3) tick();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("sw_wait_vec", act, cv(0,0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0));
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("abort_outputs", act, 18'h0);
    mem_ready = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_then_fetch", act, v_fetch);
    tick();

    // Randomized instruction stream.
    apply_reset(1);
    for (int k = 0; k < 80; k++) begin
      logic [5:0] ops [9];
      ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
              6'b000010, 6'b001000, 6'b111111, 6'b010101};
      run_instr(ops[$urandom % 9], 0, cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/main_control_fsm.md
# main_control_fsm

Multicycle MIPS main control unit: a Moore state machine that sequences every instruction through fetch, decode, execute, memory and writeback. It sits directly upstream of the ALU control stage, supplying the 2-bit ALUOpcode it consumes, plus all datapath enables (PC, IR, memory, register file, mux selects). Memory accesses use a ready handshake so the FSM stalls on slow memory.

## Interface
- Parameters: none.
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- op_31_26  in  6  opcode field from the instruction register; valid from DECODE onward.
- mem_ready  in  1  memory completes the current read/write this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  conditional PC load; datapath gates with zero flag.
- branch_ne  out  1  invert zero-flag condition (bne).
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  register write data: 0 = ALUOut, 1 = MDR.
- RegDst  out  1  destination: 0 = rt, 1 = rd.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  0 = PC, 1 = rs.
- ALUSrcB  out  2  00 = rt, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
- ALUOpcode  out  2  00 = add, 01 = subtract, 10 = funct-decoded; to ALU control.
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- illegal_op  out  1  sticky flag: unsupported opcode decoded.

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, addi 001000.
- States and asserted outputs (unlisted outputs 0):
  - FETCH: MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOpcode=00, PCSource=00; IRWrite and PCWrite only when mem_ready=1. Stays while mem_ready=0; -> DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOpcode=00. -> MEM_ADDR (lw/sw), EXECUTE (R), BRANCH (beq/bne), JUMP (j), ADDI_EXEC (addi); else set illegal_op, instr_done=1, -> FETCH.
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOpcode=00. -> MEM_READ (lw) / MEM_WRITE (sw).
  - MEM_READ: MemRead, IorD=1; hold until mem_ready; -> MEM_WB.
  - MEM_WB: RegWrite, MemtoReg=1, RegDst=0, instr_done. -> FETCH.
  - MEM_WRITE: MemWrite, IorD=1; hold until mem_ready; instr_done in the mem_ready cycle; -> FETCH.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOpcode=10. -> ALU_WB.
  - ALU_WB: RegWrite, RegDst=1, MemtoReg=0, instr_done. -> FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOpcode=01, PCWriteCond, PCSource=01, branch_ne=(op==bne), instr_done. -> FETCH.
  - JUMP: PCWrite, PCSource=10, instr_done. -> FETCH.
  - ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOpcode=00. -> ADDI_WB.
  - ADDI_WB: RegWrite, RegDst=0, MemtoReg=0, instr_done. -> FETCH.
- illegal_op clears only on reset; execution continues with next fetch.

## Timing
- Outputs are combinational from the state register (Moore), except FETCH IRWrite/PCWrite and MEM_WRITE instr_done, which are qualified by mem_ready.
- Reset: state <= FETCH, illegal_op <= 0; while rst=1 every output forced 0. First cycle after rst falls is FETCH.
- Latency with mem_ready tied 1: R-type 4, lw 5, sw 4, beq/bne 3, j 3, addi 4 cycles. Each mem_ready=0 cycle in FETCH/MEM_READ/MEM_WRITE adds one.
- Strobes (MemRead/MemWrite) held constant while waiting; no state change until mem_ready.
- rst asserted mid-instruction aborts it next edge; no partial writeback follows.

## Configuration
- MIPS_CTRL_BNE_EN defined: opcode 000101 goes to BRANCH with branch_ne=1.
- Undefined: 000101 is illegal (sets illegal_op), branch_ne tied 0.

## Structure
- Package mips_ctrl_pkg: state enum, opcode constants, ALUOpcode encodings (ADD/SUB/FUNCT), ALUSrcB and PCSource encodings.
- Sub-module mips_ctrl_outdec: pure combinational state(+mem_ready, opcode) -> control-vector decoder; top holds state register and illegal_op.

## Test plan
- Reset held 3 cycles -> all outputs 0; release -> FETCH with MemRead=1, ALUSrcB=01, ALUOpcode=00.
- R-type (000000), mem_ready=1 -> 4 cycles; EXECUTE shows ALUOpcode=10; ALU_WB RegWrite=1, RegDst=1; instr_done pulse at cycle 4.
- lw (100011) with mem_ready low 2 cycles in MEM_READ -> 7 cycles total; MemRead, IorD=1 stable during stall; MEM_WB MemtoReg=1.
- beq (000100) -> 3 cycles; BRANCH ALUOpcode=01, PCWriteCond=1, PCSource=01, branch_ne=0; bne with macro -> branch_ne=1, without -> illegal_op=1.
- Opcode 111111 -> illegal_op rises after DECODE, FETCH next; flag stays 1 across following addi (ADDI_EXEC ALUSrcB=10) until rst.
- rst asserted in MEM_WRITE while mem_ready=0 -> next cycle outputs 0, MemWrite never completes; after release FETCH.
